// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range through one read port and streams each
// value out as a valid/ready beat, accumulating a mod-2**W checksum.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int unsigned W = DATA_W,
    parameter int unsigned A = ADDR_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    input  logic [A-1:0] EndAddr,
    output logic [A-1:0] RegAddr,
    input  logic [W-1:0] RegData,
    output logic         DumpValid,
    input  logic         DumpReady,
    output logic [W-1:0] DumpData,
    output logic [A-1:0] DumpAddr,
    output logic         DumpLast,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Checksum
);

    dump_state_t  state_q, state_d;
    logic [A-1:0] ptr_q, ptr_d;
    logic [A-1:0] end_q, end_d;
    logic [W-1:0] data_q, data_d;
    logic [A-1:0] addr_q, addr_d;
    logic         last_q, last_d;
    logic [W-1:0] csum_q, csum_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            csum_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            csum_q  <= csum_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath; status flags are registered from the next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        end_d   = end_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        csum_d  = csum_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    ptr_d   = StartAddr;
                    end_d   = EndAddr;
                    csum_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = RegData;
                addr_d  = ptr_q;
                last_d  = (ptr_q == end_q);
                state_d = SEND;
            end
            SEND: begin
                if (DumpReady) begin
                    csum_d = W'(csum_q + data_q);
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = A'(ptr_q + A'(1));
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    assign RegAddr   = ptr_q;
    assign DumpValid = valid_q;
    assign DumpData  = data_q;
    assign DumpAddr  = addr_q;
    assign DumpLast  = last_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Checksum  = csum_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side master for the processor register file: on command, walks a range of register addresses through one read port and streams each value out.
- Output is a valid/ready beat stream, one register per beat, with a running checksum.
- Sits beside the register file. Drives one RaddrX input and consumes the matching DataOutX.
- Used by the test harness and debug path to dump architectural state after a program halts.

Parameters:
W, 8, data path width (matches register file)
A, 4, register address width; 2**A registers addressable

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  synchronous, active-high
Start  input  1  one-cycle request to begin a dump; honoured only in IDLE
StartAddr  input  A  first register to dump, sampled with Start
EndAddr  input  A  last register to dump, sampled with Start
RegAddr  output  A  read address to register file read port
RegData  input  W  combinational read data returned for RegAddr
DumpValid  output  1  beat valid
DumpReady  input  1  downstream accept
DumpData  output  W  register value of current beat
DumpAddr  output  A  register index of current beat
DumpLast  output  1  current beat is final of range
Busy  output  1  high in any state except IDLE
Done  output  1  one-cycle pulse after final beat accepted
Checksum  output  W  sum mod 2**W of all accepted beats of latest dump

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset); all registers update on posedge Clk.
- Reset: state IDLE; ptr, end, DumpData, DumpAddr, Checksum = 0; DumpValid, DumpLast, Busy, Done = 0.
- RegAddr = ptr at all times, combinationally.
- IDLE:
  - Start=1 latches ptr<=StartAddr, end<=EndAddr, Checksum<=0, then goes to LOAD.
  - Start=0 stays in IDLE.
- LOAD (1 cycle):
  - Captures DumpData<=RegData, DumpAddr<=ptr, DumpLast<=(ptr==end).
  - Goes to SEND.
- SEND:
  - DumpValid=1. DumpData, DumpAddr and DumpLast are held stable until the handshake (DumpValid & DumpReady).
  - On handshake, Checksum<=Checksum+DumpData, truncated to W bits.
  - If DumpLast: go to DONE. Else ptr<=ptr+1 (mod 2**A), go to LOAD.
  - No handshake: stay in SEND; DumpValid must not drop.
- DONE (1 cycle): Done=1, Busy=1, then IDLE. Checksum holds until the next accepted Start.
- Throughput: max one beat per 2 cycles. First DumpValid appears 2 cycles after the Start cycle.
- Beat count = ((EndAddr-StartAddr) mod 2**A)+1:
  - StartAddr==EndAddr gives exactly 1 beat.
  - EndAddr<StartAddr wraps through 2**A-1 to 0.
  - StartAddr=EndAddr+1 (mod) dumps all 2**A registers.
- Start while Busy: ignored; no relatch, no restart.
- Snapshot semantics: the value is captured in LOAD.
  - A register-file write on the LOAD posedge is not visible; the old value is captured.
  - Writes after capture do not alter the pending beat.
- Reset mid-dump: immediate return to IDLE with reset values. No Done pulse; partial Checksum is cleared.
- DumpReady is ignored outside SEND.

Decomposition:
- Shared package regfile_pkg holds:
  - default W=8, A=4 constants
  - typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} dump_state_t
- Single module; no sub-module. FSM, pointer and checksum accumulator are small enough to live together.
- The bench instantiates the existing register file and ties RegAddr/RegData to one read port.

Test Plan:
Preload reg[i]=8'h10+i, Start StartAddr=2 EndAddr=5, DumpReady=1 -> beats (2,12),(3,13),(4,14),(5,15); DumpLast only on addr 5; Checksum=8'h4E; Done one cycle after last handshake; first DumpValid 2 cycles after Start.
Wrap: StartAddr=14 EndAddr=1 -> addresses 14,15,0,1 in order, 4 beats, DumpLast on 1.
Full dump: Start=3 End=2 with reg[i]=8'hFF -> 16 beats; Checksum=8'hF0 (mod-256 wrap).
Backpressure: DumpReady low 5 cycles in SEND of beat 0 -> DumpValid/Data/Addr constant throughout; no beat lost or duplicated; Checksum counts beat once.
Start while Busy with different range -> ignored, original range completes; Start in DONE cycle also ignored.
Reset asserted during SEND of beat 2 of 4 -> next cycle all outputs 0, state IDLE, no Done; new Start 0..0 gives single beat with DumpLast=1.
